// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX and RX byte FIFOs, a fixed baud divider, and a registered
// status+data word that is captured on every read strobe.
module uart_mmio #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  dataIn,
    input  logic        write,
    input  logic        read,
    output logic [15:0] dataOut,
    input  logic        RX,
    output logic        TX
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uartState;

    // Bus handshake: write and read are levels; exactly one access happens per rising edge.
    // A read edge while write is high is ignored, so a CPU write never pops the RX FIFO.
    logic writeQ, readQ, pushEdge, popEdge;
    assign pushEdge = write & ~writeQ;
    assign popEdge  = read & ~readQ & ~write;

    logic [7:0]  txMem [FIFO_DEPTH];
    logic [7:0]  rxMem [FIFO_DEPTH];
    logic [AW:0] txWr, txRd, rxWr, rxRd;
    logic        txEmpty, txFull, rxEmpty, rxFull;
    logic        txPush, txPop, rxPush, rxPop, rxDone, rxOvfSet, rxFrameErrSet;
    logic        rxOvf, frameErr, txBusy;

    assign txEmpty = (txWr == txRd);
    assign txFull  = (txWr[AW] != txRd[AW]) && (txWr[AW-1:0] == txRd[AW-1:0]);
    assign rxEmpty = (rxWr == rxRd);
    assign rxFull  = (rxWr[AW] != rxRd[AW]) && (rxWr[AW-1:0] == rxRd[AW-1:0]);
    assign txPush  = pushEdge & ~txFull;
    assign rxPop   = popEdge & ~rxEmpty;
    assign rxPush  = rxDone & ~rxFull;
    assign rxOvfSet = rxDone & rxFull;

    // TX state machine registers and next-state values
    uartState    txState, txStateN;
    logic [CW-1:0] txCnt, txCntN;
    logic [2:0]  txBit, txBitN;
    logic [7:0]  txShift, txShiftN;
    logic        txLine, txLineN;

    // RX synchronizer and state machine
    logic [1:0]  rxSync;
    logic        rxS;
    uartState    rxState, rxStateN;
    logic [CW-1:0] rxCnt, rxCntN;
    logic [2:0]  rxBit, rxBitN;
    logic [7:0]  rxShift, rxShiftN;

    assign rxS    = rxSync[1];
    assign TX     = txLine;
    assign txBusy = (txState != S_IDLE) || !txEmpty;

    always_ff @(posedge CLK) begin
        if (txPush) txMem[txWr[AW-1:0]] <= dataIn;
        if (rxPush) rxMem[rxWr[AW-1:0]] <= rxShift;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            writeQ   <= 1'b0;
            readQ    <= 1'b0;
            txWr     <= '0;
            txRd     <= '0;
            rxWr     <= '0;
            rxRd     <= '0;
            rxOvf    <= 1'b0;
            frameErr <= 1'b0;
            dataOut  <= 16'h0000;
            rxSync   <= 2'b11;
            txState  <= S_IDLE;
            txCnt    <= '0;
            txBit    <= 3'd0;
            txShift  <= 8'h00;
            txLine   <= 1'b1;
            rxState  <= S_IDLE;
            rxCnt    <= '0;
            rxBit    <= 3'd0;
            rxShift  <= 8'h00;
        end else begin
            writeQ  <= write;
            readQ   <= read;
            rxSync  <= {rxSync[0], RX};
            txState <= txStateN;
            txCnt   <= txCntN;
            txBit   <= txBitN;
            txShift <= txShiftN;
            txLine  <= txLineN;
            rxState <= rxStateN;
            rxCnt   <= rxCntN;
            rxBit   <= rxBitN;
            rxShift <= rxShiftN;
            if (txPush) txWr <= txWr + PTR_ONE;
            if (txPop)  txRd <= txRd + PTR_ONE;
            if (rxPush) rxWr <= rxWr + PTR_ONE;
            if (rxPop)  rxRd <= rxRd + PTR_ONE;
            // Flags are captured into the snapshot first; a new event in the same cycle wins.
            if (popEdge) begin
                dataOut  <= {~rxEmpty, txFull, rxOvf, frameErr, txBusy, 3'b000,
                             rxEmpty ? 8'h00 : rxMem[rxRd[AW-1:0]]};
                rxOvf    <= 1'b0;
                frameErr <= 1'b0;
            end
            if (rxOvfSet)      rxOvf    <= 1'b1;
            if (rxFrameErrSet) frameErr <= 1'b1;
        end
    end

    always_comb begin
        txStateN = txState;
        txCntN   = txCnt;
        txBitN   = txBit;
        txShiftN = txShift;
        txLineN  = txLine;
        txPop    = 1'b0;
        case (txState)
            S_IDLE: if (!txEmpty) begin
                txPop    = 1'b1;
                txShiftN = txMem[txRd[AW-1:0]];
                txLineN  = 1'b0;
                txCntN   = CNT_BIT;
                txStateN = S_START;
            end
            S_START: if (txCnt != '0) txCntN = txCnt - CNT_ONE;
            else begin
                txLineN  = txShift[0];
                txShiftN = {1'b0, txShift[7:1]};
                txBitN   = 3'd0;
                txCntN   = CNT_BIT;
                txStateN = S_DATA;
            end
            S_DATA: if (txCnt != '0) txCntN = txCnt - CNT_ONE;
            else begin
                txCntN = CNT_BIT;
                if (txBit == 3'd7) begin
                    txLineN  = 1'b1;
                    txStateN = S_STOP;
                end else begin
                    txLineN  = txShift[0];
                    txShiftN = {1'b0, txShift[7:1]};
                    txBitN   = txBit + 3'd1;
                end
            end
            S_STOP: if (txCnt != '0) txCntN = txCnt - CNT_ONE;
            else txStateN = S_IDLE;
            default: txStateN = S_IDLE;
        endcase
    end

    // Start is confirmed half a bit in; every later sample lands mid-bit.
    always_comb begin
        rxStateN      = rxState;
        rxCntN        = rxCnt;
        rxBitN        = rxBit;
        rxShiftN      = rxShift;
        rxDone        = 1'b0;
        rxFrameErrSet = 1'b0;
        case (rxState)
            S_IDLE: if (!rxS) begin
                rxCntN   = CNT_HALF;
                rxStateN = S_START;
            end
            S_START: if (rxCnt != '0) rxCntN = rxCnt - CNT_ONE;
            else if (rxS) rxStateN = S_IDLE;
            else begin
                rxStateN = S_DATA;
                rxCntN   = CNT_BIT;
                rxBitN   = 3'd0;
            end
            S_DATA: if (rxCnt != '0) rxCntN = rxCnt - CNT_ONE;
            else begin
                rxShiftN = {rxS, rxShift[7:1]};
                rxCntN   = CNT_BIT;
                if (rxBit == 3'd7) rxStateN = S_STOP;
                else rxBitN = rxBit + 3'd1;
            end
            S_STOP: if (rxCnt != '0) rxCntN = rxCnt - CNT_ONE;
            else begin
                if (rxS) rxDone = 1'b1;
                else rxFrameErrSet = 1'b1;
                rxStateN = S_IDLE;
            end
            default: rxStateN = S_IDLE;
        endcase
    end
endmodule
